// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-number-generator blocks.
//
// Contents:
//   SC_N       default value / LFSR width, shared with the LFSR instance
//   SC_LEN_W   default stream-length and ones-counter width
//   sc_state_t control FSM states for sc_stream_gen
package sc_pkg;

    localparam int SC_N     = 8;
    localparam int SC_LEN_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RESTART = 2'd1,
        ST_STREAM  = 2'd2
    } sc_state_t;

endpackage

// File: rtl/sc_compare.sv
// N-bit unsigned less-than comparator used to turn a random word into a
// stochastic bit. Kept separate so later SNG variants can reuse it.
//
// Ports:
//   a   in  N  left operand (random word)
//   b   in  N  right operand (encoded value)
//   lt  out 1  1 when a < b, unsigned
module sc_compare
    import sc_pkg::*;
#(
    parameter int N = SC_N
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         lt
);

    assign lt = (a < b);

endmodule

// File: rtl/sc_stream_gen.sv
// Stochastic number generator control stage. Accepts a value and a stream
// length, restarts the sibling LFSR from its seed, then emits one bit per
// handshake: bit = (lfsr_data < value). Reports the count of ones when the
// stream completes.
//
// Ports:
//   clk, rst                synchronous active-high reset
//   in_valid/in_ready       request handshake (ready only in IDLE)
//   in_value [N], in_len    value to encode, number of bits (0 allowed)
//   lfsr_restart            reload LFSR seed (one cycle per request)
//   lfsr_enable             advance LFSR one step
//   lfsr_data [N]           current LFSR word
//   bit_valid/bit_ready     bitstream handshake
//   bit_out, bit_last       stochastic bit and end-of-stream marker
//   done, ones [LEN_W]      completion pulse and count of ones
module sc_stream_gen
    import sc_pkg::*;
#(
    parameter int N     = SC_N,
    parameter int LEN_W = SC_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_value,
    input  logic [LEN_W-1:0] in_len,
    output logic             lfsr_restart,
    output logic             lfsr_enable,
    input  logic [N-1:0]     lfsr_data,
    output logic             bit_valid,
    input  logic             bit_ready,
    output logic             bit_out,
    output logic             bit_last,
    output logic             done,
    output logic [LEN_W-1:0] ones
);

    sc_state_t        state_q, state_d;
    logic [N-1:0]     value_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] ones_acc_q;
    logic [LEN_W-1:0] ones_q;
    logic             done_q;

    logic             lt;
    logic             handshake;
    logic             last;

    sc_compare #(.N(N)) u_compare (
        .a  (lfsr_data),
        .b  (value_q),
        .lt (lt)
    );

    // len_q is never 0 while in STREAM, so len_q-1 cannot wrap here.
    assign last      = (state_q == ST_STREAM) && (cnt_q == len_q - LEN_W'(1));
    assign handshake = bit_valid & bit_ready;

    // NOTE: every output of this block gets a default before the case, so a
    // state that forgets to drive one cannot infer a latch.
    always_comb begin
        state_d      = state_q;
        in_ready     = 1'b0;
        lfsr_restart = 1'b0;
        bit_valid    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = ST_RESTART;
            end
            ST_RESTART: begin
                lfsr_restart = 1'b1;
                state_d      = (len_q == '0) ? ST_IDLE : ST_STREAM;
            end
            ST_STREAM: begin
                bit_valid = 1'b1;
                if (bit_ready && last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The LFSR only advances on a handshake, so bit_out holds during stalls.
    assign lfsr_enable = handshake;
    assign bit_out     = bit_valid & lt;
    assign bit_last    = last;
    assign done        = done_q;
    assign ones        = ones_q;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            value_q    <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            ones_acc_q <= '0;
            ones_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;

            if (state_q == ST_IDLE && in_valid) begin
                value_q    <= in_value;
                len_q      <= in_len;
                cnt_q      <= '0;
                ones_acc_q <= '0;
                // Cleared here so the RESTART cycle already shows ones=0.
                ones_q     <= '0;
            end

            if (state_q == ST_RESTART && len_q == '0) begin
                done_q <= 1'b1;
            end

            if (handshake) begin
                cnt_q      <= cnt_q + LEN_W'(1);
                ones_acc_q <= ones_acc_q + LEN_W'(bit_out);
                if (last) begin
                    ones_q <= ones_acc_q + LEN_W'(bit_out);
                    done_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sc_stream_gen.sv
// Directed bench for sc_stream_gen with a behavioural 8-bit LFSR sibling
// (x^8 + x^6 + x^5 + x^4 + 1, seed 8'h01).
module tb_sc_stream_gen;

    localparam logic [7:0] SEED = 8'h01;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_value = '0;
    logic [15:0] in_len = '0;
    logic        lfsr_restart;
    logic        lfsr_enable;
    logic [7:0]  lfsr_q;
    logic        bit_valid;
    logic        bit_ready = 1'b1;
    logic        bit_out;
    logic        bit_last;
    logic        done;
    logic [15:0] ones;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    sc_stream_gen #(.N(8), .LEN_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_value     (in_value),
        .in_len       (in_len),
        .lfsr_restart (lfsr_restart),
        .lfsr_enable  (lfsr_enable),
        .lfsr_data    (lfsr_q),
        .bit_valid    (bit_valid),
        .bit_ready    (bit_ready),
        .bit_out      (bit_out),
        .bit_last     (bit_last),
        .done         (done),
        .ones         (ones)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lfsr_step(input logic [7:0] d);
        return {d[6:0], d[7] ^ d[5] ^ d[4] ^ d[3]};
    endfunction

    // Sibling LFSR model.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst || lfsr_restart) lfsr_q <= SEED;
        else if (lfsr_enable)    lfsr_q <= lfsr_step(lfsr_q);
    end

    function automatic logic [15:0] ref_ones(input logic [7:0] val, input int len);
        logic [7:0]  l = SEED;
        logic [15:0] n = '0;
        for (int i = 0; i < len; i++) begin
            if (l < val) n++;
            l = lfsr_step(l);
        end
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issues one request and follows the whole stream. stall_at >= 0 holds
    // bit_ready low for 3 cycles when bit stall_at is presented.
    task automatic run_stream(input logic [7:0] val, input int len, input int stall_at,
                              input bit hold_valid, output logic [63:0] bits,
                              output logic [15:0] ones_seen);
        int          t0;
        int          k = 0;
        int          guard = 0;
        int          stall_left;
        int          n_stall = 0;
        logic [7:0]  exp_l = SEED;
        logic [15:0] exp_ones = '0;
        logic        exp_bit;
        bits       = '0;
        stall_left = (stall_at >= 0) ? 3 : 0;

        @(negedge clk);
        check("idle_ready", in_ready, 1);
        t0       = cyc;
        in_valid = 1'b1;
        in_value = val;
        in_len   = len[15:0];
        bit_ready = 1'b1;

        @(negedge clk);
        if (!hold_valid) in_valid = 1'b0;
        in_value = ~val;
        in_len   = 16'd5;
        check("restart_pulse", lfsr_restart, 1);
        check("restart_ready", in_ready, 0);
        check("restart_valid", bit_valid, 0);
        check("restart_ones_clr", ones, 0);
        check("restart_time", cyc - t0, 1);

        while (k < len && guard < 1000) begin
            @(negedge clk);
            guard++;
            if (guard == 1) check("first_bit_time", cyc - t0, 2);
            exp_bit = (exp_l < val);
            check("bit_valid", bit_valid, 1);
            check("busy_ready", in_ready, 0);
            check("restart_low", lfsr_restart, 0);
            check("lfsr_data", lfsr_q, exp_l);
            check("bit_out", bit_out, exp_bit);
            check("bit_last", bit_last, (k == len - 1));
            check("done_low", done, 0);
            if (k == stall_at && stall_left > 0) begin
                bit_ready = 1'b0;
                stall_left--;
                n_stall++;
            end else begin
                bit_ready = 1'b1;
            end
            #1;
            check("lfsr_enable", lfsr_enable, bit_ready);
            if (bit_ready) begin
                bits[k]  = exp_bit;
                exp_ones = exp_ones + 16'(exp_bit);
                exp_l    = lfsr_step(exp_l);
                k++;
            end
        end
        if (guard >= 1000) check("stream_timeout", 0, 1);

        @(negedge clk);
        in_valid  = 1'b0;
        bit_ready = 1'b1;
        check("done_pulse", done, 1);
        check("done_ones", ones, exp_ones);
        check("done_ready", in_ready, 1);
        check("done_valid", bit_valid, 0);
        check("done_time", cyc - t0, len + 2 + n_stall);
        ones_seen = ones;

        @(negedge clk);
        check("done_single", done, 0);
        check("ones_hold", ones, exp_ones);
        check("idle_valid", bit_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] bits_a, bits_b;
        logic [15:0] ones_a, ones_b, ones_ref;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_restart", lfsr_restart, 0);
        check("rst_enable", lfsr_enable, 0);
        check("rst_valid", bit_valid, 0);
        check("rst_last", bit_last, 0);
        check("rst_done", done, 0);
        check("rst_ones", ones, 0);

        // Value 0: every bit 0, ones 0.
        run_stream(8'h00, 16, -1, 1'b0, bits_a, ones_a);
        check("v0_bits", bits_a[15:0], 16'h0000);
        check("v0_ones", ones_a, 16'd0);

        // Value 0x80, 64 bits, no stalls.
        ones_ref = ref_ones(8'h80, 64);
        run_stream(8'h80, 64, -1, 1'b0, bits_a, ones_a);
        check("v80_ones", ones_a, ones_ref);

        // Same request with a 3-cycle stall mid-stream.
        run_stream(8'h80, 64, 20, 1'b0, bits_b, ones_b);
        check("stall_ones", ones_b, ones_a);
        check("stall_bits_lo", bits_b[31:0], bits_a[31:0]);
        check("stall_bits_hi", bits_b[63:32], bits_a[63:32]);

        // Zero-length stream.
        run_stream(8'h55, 0, -1, 1'b0, bits_b, ones_b);
        check("len0_ones", ones_b, 16'd0);

        // Value 0xFF: only the word 0xFF yields a 0.
        run_stream(8'hFF, 40, -1, 1'b0, bits_b, ones_b);
        check("vff_ones", ones_b, ref_ones(8'hFF, 40));

        // in_valid held during the stream; two identical requests.
        run_stream(8'h3C, 24, -1, 1'b1, bits_a, ones_a);
        run_stream(8'h3C, 24, -1, 1'b1, bits_b, ones_b);
        check("repeat_bits", bits_b[23:0], bits_a[23:0]);
        check("repeat_ones", ones_b, ref_ones(8'h3C, 24));

        // Reset at bit 5 of a 32-bit stream.
        @(negedge clk);
        in_valid = 1'b1;
        in_value = 8'h80;
        in_len   = 16'd32;
        bit_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("pre_rst_valid", bit_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_restart", lfsr_restart, 0);
        check("mid_rst_enable", lfsr_enable, 0);
        check("mid_rst_valid", bit_valid, 0);
        check("mid_rst_last", bit_last, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_ones", ones, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_no_done", done, 0);
            check("post_rst_no_valid", bit_valid, 0);
        end
        run_stream(8'h80, 64, -1, 1'b0, bits_b, ones_b);
        check("post_rst_ones", ones_b, ones_ref);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sc_stream_gen.md
# sc_stream_gen

Stochastic number generator (SNG) control stage sitting directly downstream of the LFSR random source. It accepts a binary value and a stream length, restarts the LFSR from its seed, and emits a stochastic bitstream: each bit is 1 when the current LFSR word is less than the value. Bits leave over a valid/ready interface, and the block reports the count of ones when each stream completes.

## Interface
Parameters:
- N, 8, value width; equals the LFSR width.
- LEN_W, 16, stream-length and ones-counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request; high only in IDLE.
- in_value  in  N  unsigned binary value to encode.
- in_len  in  LEN_W  number of bits to emit (0 allowed).
- lfsr_restart  out  1  to LFSR restart; reloads the seed.
- lfsr_enable  out  1  to LFSR enable; advances one step.
- lfsr_data  in  N  LFSR register contents.
- bit_valid  out  1  bitstream bit valid.
- bit_ready  in  1  downstream accepts bit.
- bit_out  out  1  stochastic bit.
- bit_last  out  1  final bit of the stream; qualified by bit_valid.
- done  out  1  one-cycle pulse after the final bit handshake.
- ones  out  LEN_W  count of ones in the completed stream.

## Operation
- States: IDLE, RESTART, STREAM.
- IDLE:
  - in_ready=1.
  - On in_valid: latch value_q=in_value and len_q=in_len, clear cnt and ones_acc, then go to RESTART.
- RESTART:
  - lfsr_restart=1 for exactly one cycle.
  - If len_q==0, go to IDLE and pulse done with ones=0. No bit_valid is ever asserted for that stream.
  - Otherwise go to STREAM.
- STREAM:
  - bit_valid=1.
  - bit_out = (lfsr_data < value_q), unsigned N-bit compare, combinational from lfsr_data.
  - lfsr_enable = bit_valid & bit_ready.
  - On each handshake: cnt+=1 and ones_acc+=bit_out.
  - bit_last = (cnt == len_q-1).
  - Handshake with bit_last set: go to IDLE, register ones = final ones_acc, pulse done.
- Outputs hold while bit_ready=0: bit_out stays stable, because the LFSR does not advance.
- in_valid outside IDLE is ignored; nothing is queued.
- ones holds its value until the next accepted request clears it, at the RESTART cycle.
- Width rule: len_q ≤ 2^LEN_W−1, so ones cannot overflow LEN_W.

## Timing
- Reset values:
  - State IDLE, so in_ready=1.
  - lfsr_restart=0, lfsr_enable=0, bit_valid=0, bit_last=0, done=0, ones=0, cnt=0.
- Cycle sequence (accept at cycle T):
  - T+1: RESTART, lfsr_restart=1.
  - T+2: first bit_valid; the bit is compared against the seed.
- With bit_ready held high, one bit per cycle. The last bit is at T+1+len. done occurs on the cycle after the last handshake, and in_ready=1 on that same cycle.
- Minimum request-to-request spacing is len+2 cycles. A len==0 request completes in 2 cycles.
- Reset mid-stream:
  - Abandons the stream immediately; no done pulse.
  - All outputs return to their reset values in the cycle after the rst cycle.
- The seed is reloaded on every request, so identical requests give identical streams.

## Structure
- Shared package sc_pkg holds:
  - The state enum (IDLE, RESTART, STREAM).
  - Default N and LEN_W constants, shared with the LFSR instance.
- One sub-module, sc_compare: N-bit unsigned less-than, reused by later SNG variants.
- The LFSR is instantiated by the parent as a sibling, not inside this block.

## Test plan
- N=8, in_value=0, in_len=16 → 16 bits all 0, bit_last on the 16th, done with ones=0.
- in_value=8'h80, in_len=64, bit_ready=1 → first bit_valid at T+2. bit_out and ones match a reference model of the LFSR from its seed. done at T+66.
- Same request with bit_ready low 3 cycles mid-stream → bit_out and lfsr_data stable, lfsr_enable=0, cnt unchanged. Final ones equals the uninterrupted run.
- in_len=0 → lfsr_restart at T+1, done at T+2 with ones=0, bit_valid never asserted.
- in_valid held high during STREAM → in_ready=0 and no second latch. Two back-to-back identical requests yield bit-identical streams.
- rst asserted at bit 5 of a 32-bit stream → no done, all outputs at reset values on the cycle after rst. A new request then runs correctly from the seed.
